mem_responder: RTL

Backing-memory responder that serves the cache's RAM-side request port. It accepts one read or write request at a time through a req/ack handshake and stores data in an internal synchronous array. It inserts a programmable number of wait cycles before acknowledging, so the cache miss and write-back paths are exercised against realistic memory latency. It sits between the cache block and the board, taking the place of a bare RAM instance.

---
 rtl/mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: backing-memory responder for the cache's RAM-side port.
// One read or write is accepted at a time. A programmable number of wait
// cycles (LATENCY, 0..15) is inserted before the one-cycle ack pulse.
// Optional feature macro: MEM_RESP_STATS_EN adds saturating rd_count and
// wr_count outputs.
//
// Handshake: in IDLE, an edge with req=1 accepts the request and latches
// addr/wdata/wren. busy stays high until the request completes. The access
// happens on the edge that enters ACK. ack is high for exactly one cycle,
// and req is ignored while busy. Holding req high therefore produces a new
// request on the first IDLE edge after ACK.
module mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [1:0]        o_dbg_state
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wren;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

  logic                w_access;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic                w_acc_wren;

`ifdef MEM_RESP_STATS_EN
  logic [15:0]         r_rd_count;
  logic [15:0]         r_wr_count;
`endif

  // With LATENCY=0 the access happens on the accept edge, so the request is
  // taken straight from the ports; otherwise the latched copies are used.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_acc_addr  = addr;
      w_acc_wdata = wdata;
      w_acc_wren  = wren;
    end else begin
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_wren  = r_wren;
    end
  end

  // Next-state logic, wait counter and access strobe.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_access   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_cnt_next = LAT4;
          if (LAT4 == 4'd0) begin
            w_next   = S_ACK;
            w_access = 1'b1;
          end else begin
            w_next   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        // <= 1 rather than == 1 so a corrupted zero count cannot lock up.
        if (r_cnt <= 4'd1) begin
          w_next     = S_ACK;
          w_access   = 1'b1;
          w_cnt_next = 4'd0;
        end
      end
      S_ACK: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = 4'd0;
      end
    endcase
  end

  // State register, request latches and registered response data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wren  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && req) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_wren  <= wren;
      end
      if (w_access) begin
        r_rdata <= w_acc_wren ? w_acc_wdata : r_mem[w_acc_addr];
      end
    end
  end

  // Storage array: never cleared, but a write whose access edge meets reset
  // is dropped.
  always_ff @(posedge clock) begin
    if (!reset && w_access && w_acc_wren) begin
      r_mem[w_acc_addr] <= w_acc_wdata;
    end
  end

`ifdef MEM_RESP_STATS_EN
  // Saturating counts of completed reads and writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (w_access) begin
      if (w_acc_wren) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end else begin
        if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`endif

  assign ack         = (r_state == S_ACK);
  assign busy        = (r_state != S_IDLE);
  assign rdata       = r_rdata;
  assign o_dbg_state = r_state;

endmodule
